// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;
  // WBSel encodings: only WB_MEM (load result) can create a load-use hazard
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_t;
endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage operand forwarding: MEM-stage result beats WB-stage result, x0 never forwards.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_OPS = 2
) (
  input  logic [NUM_OPS-1:0][4:0] rs_ex,
  input  logic [4:0]              rd_mem,
  input  logic                    regwen_mem,
  input  logic [4:0]              rd_wb,
  input  logic                    regwen_wb,
  output logic [NUM_OPS-1:0][1:0] fwd_sel
);
  logic mem_wr, wb_wr;

  assign mem_wr = regwen_mem & (rd_mem != 5'd0);
  assign wb_wr  = regwen_wb  & (rd_wb  != 5'd0);

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    assign fwd_sel[i] = (mem_wr && rd_mem == rs_ex[i]) ? FWD_MEM :
                        (wb_wr  && rd_wb  == rs_ex[i]) ? FWD_WB  : FWD_RF;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RV32I 5-stage pipe sequencer: load-use stall, redirect flush, memory freeze, watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       Rs1_EX,
  input  logic [4:0]       Rs2_EX,
  input  logic [4:0]       Rd_EX,
  input  logic             RegWEn_EX,
  input  logic [1:0]       WBSel_EX,
  input  logic             PCsel_EX,
  input  logic [4:0]       Rd_MEM,
  input  logic             RegWEn_MEM,
  input  logic             MemReq_MEM,
  input  logic             mem_ready,
  input  logic [4:0]       Rd_WB,
  input  logic             RegWEn_WB,
  output logic             pc_en,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic [1:0]       fwdA_sel,
  output logic [1:0]       fwdB_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int              WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  hz_state_t       state, state_nx;
  logic [WD_W-1:0] wd_cnt, wd_nx;
  logic            mem_busy, load_use, redirect;
  logic            pc_en_c, en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
  logic            fl_ifid_c, fl_idex_c;
  logic [1:0][1:0] fwd_sel;

  assign mem_busy = MemReq_MEM & ~mem_ready;
  assign load_use = RegWEn_EX & (WBSel_EX == WB_MEM) & (Rd_EX != 5'd0) &
                    ((use_rs1_ID & (Rd_EX == Rs1_ID)) | (use_rs2_ID & (Rd_EX == Rs2_ID)));

  pipe_fwd_unit #(.NUM_OPS(2)) u_fwd (
    .rs_ex      ({Rs2_EX, Rs1_EX}),
    .rd_mem     (Rd_MEM),
    .regwen_mem (RegWEn_MEM),
    .rd_wb      (Rd_WB),
    .regwen_wb  (RegWEn_WB),
    .fwd_sel    (fwd_sel)
  );

  // Next state and same-cycle enables; priority HALT > mem_busy > redirect > load_use > normal
  always_comb begin
    state_nx   = state;
    wd_nx      = wd_cnt;
    redirect   = 1'b0;
    pc_en_c    = 1'b0;
    en_ifid_c  = 1'b0;
    en_idex_c  = 1'b0;
    en_exmem_c = 1'b0;
    en_memwb_c = 1'b0;
    fl_ifid_c  = 1'b0;
    fl_idex_c  = 1'b0;
    if (state == HALT) begin
      state_nx = HALT;
    end else if (mem_busy) begin
      // Whole pipe frozen; a held redirect waits for the release cycle
      if (wd_cnt == WD_LAST) begin
        state_nx = HALT;
      end else begin
        state_nx = MEM_WAIT;
        wd_nx    = wd_cnt + WD_W'(1);
      end
    end else begin
      state_nx   = RUN;
      wd_nx      = '0;
      en_idex_c  = 1'b1;
      en_exmem_c = 1'b1;
      en_memwb_c = 1'b1;
      if (PCsel_EX) begin
        redirect  = 1'b1;
        pc_en_c   = 1'b1;
        en_ifid_c = 1'b1;
        fl_ifid_c = 1'b1;
        fl_idex_c = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX
        fl_idex_c = 1'b1;
      end else begin
        pc_en_c   = 1'b1;
        en_ifid_c = 1'b1;
      end
    end
  end

  // Reset overrides: pipe held, bubbles loaded, register-file operands
  assign pc_en       = ~rst & pc_en_c;
  assign en_IF_ID    = ~rst & en_ifid_c;
  assign en_ID_EX    = ~rst & en_idex_c;
  assign en_EX_MEM   = ~rst & en_exmem_c;
  assign en_MEM_WB   = ~rst & en_memwb_c;
  assign flush_IF_ID = rst | fl_ifid_c;
  assign flush_ID_EX = rst | fl_idex_c;
  assign fwdA_sel    = rst ? FWD_RF : fwd_sel[0];
  assign fwdB_sel    = rst ? FWD_RF : fwd_sel[1];
  assign halted      = (state == HALT);

  // FSM, watchdog and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wd_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nx;
      wd_cnt <= wd_nx;
      if (!pc_en_c && state != HALT) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect)                  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed check of pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1_ID, Rs2_ID, Rs1_EX, Rs2_EX, Rd_EX, Rd_MEM, Rd_WB;
  logic use_rs1_ID, use_rs2_ID, RegWEn_EX, PCsel_EX, RegWEn_MEM, MemReq_MEM, mem_ready, RegWEn_WB;
  logic [1:0] WBSel_EX;
  logic pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, halted;
  logic [1:0] fwdA_sel, fwdB_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .Rs1_EX(Rs1_EX), .Rs2_EX(Rs2_EX), .Rd_EX(Rd_EX), .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX),
    .PCsel_EX(PCsel_EX), .Rd_MEM(Rd_MEM), .RegWEn_MEM(RegWEn_MEM), .MemReq_MEM(MemReq_MEM),
    .mem_ready(mem_ready), .Rd_WB(Rd_WB), .RegWEn_WB(RegWEn_WB),
    .pc_en(pc_en), .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX), .en_EX_MEM(en_EX_MEM),
    .en_MEM_WB(en_MEM_WB), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: consecutive frozen cycles, sticky halt, counters
  int               m_busy_run;
  bit               m_halted;
  logic [CNT_W-1:0] m_stall, m_flush;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (RegWEn_MEM && Rd_MEM != 0 && Rd_MEM == rs) return 2'b01;
    if (RegWEn_WB  && Rd_WB  != 0 && Rd_WB  == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [6:0] ctl_vec();
    return {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX};
  endfunction

  task automatic idle();
    Rs1_ID = 0; Rs2_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0;
    Rs1_EX = 0; Rs2_EX = 0; Rd_EX = 0; RegWEn_EX = 0; WBSel_EX = 2'b01; PCsel_EX = 0;
    Rd_MEM = 0; RegWEn_MEM = 0; MemReq_MEM = 0; mem_ready = 0; Rd_WB = 0; RegWEn_WB = 0;
  endtask

  // Called at a negedge with inputs applied; checks, clocks once, returns at next negedge
  task automatic step();
    bit busy, lu;
    logic [6:0] e_ctl;
    #1;
    busy = MemReq_MEM && !mem_ready;
    lu   = RegWEn_EX && WBSel_EX == 2'b00 && Rd_EX != 0 &&
           ((use_rs1_ID && Rd_EX == Rs1_ID) || (use_rs2_ID && Rd_EX == Rs2_ID));
    if (m_halted || busy) e_ctl = 7'b0000000;
    else if (PCsel_EX)    e_ctl = 7'b1111111;
    else if (lu)          e_ctl = 7'b0011101;
    else                  e_ctl = 7'b1111100;
    check("ctl",    64'(ctl_vec()),  64'(e_ctl));
    check("fwdA",   64'(fwdA_sel),   64'(fwd_exp(Rs1_EX)));
    check("fwdB",   64'(fwdB_sel),   64'(fwd_exp(Rs2_EX)));
    check("halted", 64'(halted),     64'(m_halted));
    check("stall",  64'(stall_cnt),  64'(m_stall));
    check("flush",  64'(flush_cnt),  64'(m_flush));
    @(posedge clk);
    if (!m_halted) begin
      if (busy) begin
        m_stall++;
        m_busy_run++;
        if (m_busy_run == MEM_TIMEOUT) m_halted = 1;
      end else begin
        m_busy_run = 0;
        if (PCsel_EX) m_flush++;
        else if (lu)  m_stall++;
      end
    end
    @(negedge clk);
  endtask

  // Reset asserted away from any clock edge; forwarding inputs set so 00 is a real check
  task automatic do_reset();
    idle();
    RegWEn_MEM = 1; Rd_MEM = 5'd3; Rs1_EX = 5'd3; Rs2_EX = 5'd3;
    rst = 1;
    #1;
    check("rst_ctl",    64'(ctl_vec()), 64'h03);
    check("rst_fwdA",   64'(fwdA_sel),  64'h0);
    check("rst_fwdB",   64'(fwdB_sel),  64'h0);
    check("rst_halted", 64'(halted),    64'h0);
    check("rst_stall",  64'(stall_cnt), 64'h0);
    check("rst_flush",  64'(flush_cnt), 64'h0);
    @(negedge clk);
    rst = 0;
    m_busy_run = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    @(negedge clk);
    do_reset();

    // Load-use: lw x5 in EX, consumer of x5 in ID
    RegWEn_EX = 1; WBSel_EX = 2'b00; Rd_EX = 5'd5; use_rs1_ID = 1; Rs1_ID = 5'd5;
    #1;
    check("lu_pc_en", 64'(pc_en), 64'h0);
    check("lu_flush", 64'(flush_ID_EX), 64'h1);
    step();
    idle();
    RegWEn_MEM = 1; Rd_MEM = 5'd5; Rs1_EX = 5'd5; use_rs1_ID = 1; Rs1_ID = 5'd9;
    #1;
    check("lu_fwdA", 64'(fwdA_sel), 64'h1);
    step();

    // MEM beats WB on the same register; x0 never forwards
    idle();
    RegWEn_MEM = 1; Rd_MEM = 5'd7; RegWEn_WB = 1; Rd_WB = 5'd7; Rs1_EX = 5'd7; Rs2_EX = 5'd7;
    #1; check("fwd_prio", 64'(fwdA_sel), 64'h1);
    step();
    idle();
    RegWEn_MEM = 1; RegWEn_WB = 1; Rd_WB = 5'd4; Rs2_EX = 5'd4;
    #1;
    check("fwd_x0", 64'(fwdA_sel), 64'h0);
    check("fwd_wb", 64'(fwdB_sel), 64'h2);
    step();

    // Taken redirect
    do_reset();
    PCsel_EX = 1;
    #1; check("br_ctl", 64'(ctl_vec()), 64'h7f);
    step();
    idle();
    #1; check("br_cnt", 64'(flush_cnt), 64'h1);
    step();

    // 3-cycle memory freeze then release
    do_reset();
    MemReq_MEM = 1;
    repeat (3) step();
    mem_ready = 1;
    #1; check("mw_rel_en", 64'(ctl_vec()), 64'h7c);
    check("mw_stall", 64'(stall_cnt), 64'h3);
    step();
    idle();
    step();

    // Redirect held across a 2-cycle freeze applies once
    do_reset();
    MemReq_MEM = 1; PCsel_EX = 1;
    #1; check("frz_noflush", 64'(flush_IF_ID), 64'h0);
    repeat (2) step();
    mem_ready = 1;
    #1; check("frz_rel", 64'(flush_IF_ID), 64'h1);
    step();
    idle();
    #1; check("frz_cnt", 64'(flush_cnt), 64'h1);
    step();

    // Watchdog: memory never answers
    do_reset();
    MemReq_MEM = 1;
    repeat (MEM_TIMEOUT) step();
    #1;
    check("wd_halted", 64'(halted), 64'h1);
    check("wd_stall",  64'(stall_cnt), 64'(MEM_TIMEOUT));
    mem_ready = 1; PCsel_EX = 1;
    repeat (3) step();
    check("wd_stick", 64'(stall_cnt), 64'(MEM_TIMEOUT));
    do_reset();
    #1; check("wd_clr", 64'(halted), 64'h0);
    step();

    // Randomized traffic over small register indices to make collisions common
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        Rs1_ID = 5'($urandom_range(0, 7)); Rs2_ID = 5'($urandom_range(0, 7));
        use_rs1_ID = 1'($urandom); use_rs2_ID = 1'($urandom);
        Rs1_EX = 5'($urandom_range(0, 7)); Rs2_EX = 5'($urandom_range(0, 7));
        Rd_EX = 5'($urandom_range(0, 7)); RegWEn_EX = 1'($urandom);
        WBSel_EX = 2'($urandom_range(0, 2));
        PCsel_EX = ($urandom_range(0, 5) == 0);
        Rd_MEM = 5'($urandom_range(0, 7)); RegWEn_MEM = 1'($urandom);
        MemReq_MEM = ($urandom_range(0, 3) == 0) || (blk == 3 && c > 200);
        mem_ready = (blk == 3 && c > 200) ? 1'b0 : ($urandom_range(0, 2) != 0);
        Rd_WB = 5'($urandom_range(0, 7)); RegWEn_WB = 1'($urandom);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
